// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and constants for the unified-memory port arbiter
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } arb_state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   localparam logic [31:0] DEFAULT_DMEM_BASE = 32'h0001_0000;

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// mem_arb_watchdog : cycle counter that flags a memory transfer as expired
// Built only when MEM_ARB_TIMEOUT_EN is defined.  Revision : 1.0
// ============================================================================
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // expire rises in the TIMEOUT_CYCLES-th busy cycle, like a synthetic ack
   assign expire = count & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (count && !expire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and data requesters
// Optional watchdog timeout via MEM_ARB_TIMEOUT_EN.  Revision : 1.0
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                DATA_W         = 32,
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] DMEM_BASE      = ADDR_W'(DEFAULT_DMEM_BASE),
   parameter int                STARVE_LIMIT   = 4,
   parameter int                TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [15:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              bus_err
);

   localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $fatal(1, "mem_port_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
   end

   arb_state_t          state_q, state_d;
   logic                if_gnt_q, if_gnt_d;
   logic                d_gnt_q, d_gnt_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic                d_rvalid_q, d_rvalid_d;
   logic                bus_err_q, bus_err_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

   logic              if_qual;
   logic              d_qual;
   logic              grant_valid;
   logic              winner;
   logic              busy;
   logic              timed_out;
   logic              xfer_done;
   logic [ADDR_W-1:0] d_mem_addr;

   // a requester whose rvalid is showing has just been served and sits out
   assign if_qual     = if_req & ~if_rvalid_q;
   assign d_qual      = d_req & ~d_rvalid_q;
   assign grant_valid = (state_q == IDLE) & (if_qual | d_qual);
   assign busy        = (state_q == BUSY_IF) | (state_q == BUSY_D);
   assign xfer_done   = busy & (mem_ack | timed_out);
   assign d_mem_addr  = DMEM_BASE + ADDR_W'(d_addr);

`ifdef MEM_ARB_TIMEOUT_EN
   logic wd_expire;

   mem_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (grant_valid),
      .count  (busy),
      .expire (wd_expire)
   );

   assign timed_out = wd_expire & ~mem_ack;
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      winner = REQ_IF;
      if (d_qual && (!if_qual || starve_cnt_q != STARVE_MAX)) begin
         winner = REQ_D;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req) begin
         starve_cnt_d = '0;
      end else if (grant_valid) begin
         if (winner == REQ_IF) begin
            starve_cnt_d = '0;
         end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      if_gnt_d    = 1'b0;
      d_gnt_d     = 1'b0;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      bus_err_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               mem_req_d = 1'b1;
               if (winner == REQ_D) begin
                  state_d     = BUSY_D;
                  d_gnt_d     = 1'b1;
                  mem_we_d    = d_we;
                  mem_addr_d  = d_mem_addr;
                  mem_wdata_d = d_wdata;
               end else begin
                  state_d     = BUSY_IF;
                  if_gnt_d    = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
               end
            end
         end
         BUSY_IF, BUSY_D: begin
            if (xfer_done) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               bus_err_d   = timed_out;
               if (state_q == BUSY_IF) begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = timed_out ? '0 : mem_rdata;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = (timed_out || mem_we_q) ? '0 : mem_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         if_gnt_q     <= 1'b0;
         d_gnt_q      <= 1'b0;
         if_rvalid_q  <= 1'b0;
         d_rvalid_q   <= 1'b0;
         bus_err_q    <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         if_gnt_q     <= if_gnt_d;
         d_gnt_q      <= d_gnt_d;
         if_rvalid_q  <= if_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         bus_err_q    <= bus_err_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign bus_err   = bus_err_q;
   // the core is released during reset even if its requests are still up
   assign stall     = rst_n & ((if_req & ~if_rvalid_q) | (d_req & ~d_rvalid_q));

endmodule
`default_nettype wire
